// File: rtl/normalizer.sv
// normalizer: iterative mantissa normalizer (leading-redundant-bit removal).
//
// Accepts a 64-bit mantissa, then shifts it left by up to STEP bits per SCAN
// cycle until it is normalized or the 63-bit shift cap is reached. The result
// is held in DONE until the consumer takes it.
//
// Normalized form:
//   unsigned: bit 63 = 1
//   signed:   bit 63 != bit 62
//
// Parameters:
//   STEP       maximum left-shift bits per SCAN cycle (1, 2, 4 or 8)
//
// Build option:
//   NORMALIZER_SIGNED_EN  when defined, in_mode selects signed (1) or unsigned
//                         (0) normalization; otherwise in_mode is ignored and
//                         normalization is always unsigned.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input offer valid
//   in_ready   block idle and able to accept an input
//   in_data    mantissa to normalize
//   in_mode    0 = unsigned, 1 = signed normalization
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   out_data   normalized mantissa
//   out_param  barrel-shifter encoding of the shift: {1'b0, (64 - k) mod 64}
//   out_count  left-shift count k applied
//   out_zero   input was all zeros
module normalizer #(
    parameter int unsigned STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [6:0]  out_param,
    output logic [5:0]  out_count,
    output logic        out_zero
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e      state_q, state_d;
    logic [63:0] work_q, work_d;
    logic [5:0]  k_q, k_d;
    logic        zero_q, zero_d;
    logic        sgn_q, sgn_d;

`ifndef NORMALIZER_SIGNED_EN
    // Port kept for interface compatibility; unsigned-only build ignores it.
    logic unused_in_mode;
    assign unused_in_mode = in_mode;
`endif

    // Per-cycle redundant-bit count over the top window.
    // Signed mode looks at bits below the sign bit, counting copies of it;
    // that equals (leading bits equal to bit63) - 1 over a STEP+1-bit window.
    logic [STEP-1:0] win;
    logic            ref_bit;
    logic            run;
    logic [5:0]      z_raw;
    logic [5:0]      z_rem;
    logic [5:0]      z;
    logic [5:0]      k_sum;

    always_comb begin
        win     = sgn_q ? work_q[62 -: STEP] : work_q[63 -: STEP];
        ref_bit = sgn_q & work_q[63];
        run     = 1'b1;
        z_raw   = '0;
        for (int i = 0; i < int'(STEP); i++) begin
            if (run && (win[STEP-1-i] == ref_bit)) begin
                z_raw = z_raw + 6'd1;
            end else begin
                run = 1'b0;
            end
        end
        z_rem = 6'd63 - k_q;
        z     = (z_raw > z_rem) ? z_rem : z_raw;
        k_sum = k_q + z;
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        k_d     = k_q;
        zero_d  = zero_q;
        sgn_d   = sgn_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d = in_data;
                    k_d    = '0;
`ifdef NORMALIZER_SIGNED_EN
                    sgn_d  = in_mode;
`else
                    sgn_d  = 1'b0;
`endif
                    if (in_data == 64'd0) begin
                        zero_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                work_d = work_q << z;
                k_d    = k_sum;
                // A short step means the window hit a significant bit.
                if ((z < 6'(STEP)) || (k_sum == 6'd63)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            work_q  <= '0;
            k_q     <= '0;
            zero_q  <= 1'b0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            k_q     <= k_d;
            zero_q  <= zero_d;
            sgn_q   <= sgn_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = work_q;
    assign out_count = k_q;
    // (64 - k) mod 64 is just the 6-bit two's complement of k.
    assign out_param = {1'b0, 6'd0 - k_q};
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_normalizer.sv
module tb_normalizer;

    localparam int unsigned STEP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [6:0]  out_param;
    logic [5:0]  out_count;
    logic        out_zero;

    normalizer #(.STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_param (out_param),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  k;
        logic [6:0]  param;
        logic        zero;
        int          scans;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;

    // Bit-at-a-time reference normalizer.
    function automatic exp_t model(input logic [63:0] d, input logic m);
        exp_t e;
        logic sg;
`ifdef NORMALIZER_SIGNED_EN
        sg = m;
`else
        sg = m & 1'b0;  // mode ignored in the unsigned-only build
`endif
        e.k    = '0;
        e.zero = (d == 64'd0);
        e.data = d;
        if (!e.zero) begin
            while ((e.k < 6'd63) && (sg ? (e.data[63] == e.data[62]) : !e.data[63])) begin
                e.data = e.data << 1;
                e.k    = e.k + 6'd1;
            end
        end
        e.param = {1'b0, 6'(7'd64 - {1'b0, e.k})};
        if (e.zero) e.scans = 0;
        else if ((e.k == 6'd63) && ((63 % STEP) == 0)) e.scans = 63 / STEP;
        else e.scans = int'(e.k) / int'(STEP) + 1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input exp_t e);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " in_ready"},  64'(in_ready),  64'd0);
        chk({tag, " out_data"},  out_data,       e.data);
        chk({tag, " out_count"}, 64'(out_count), 64'(e.k));
        chk({tag, " out_param"}, 64'(out_param), 64'(e.param));
        chk({tag, " out_zero"},  64'(out_zero),  64'(e.zero));
    endtask

    task automatic run_op(input string tag, input logic [63:0] d, input logic m,
                          input int hold);
        int   cnt;
        exp_t e;
        @(negedge clk);
        chk({tag, " ready before accept"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        sb.push_back(model(d, m));
        @(negedge clk);
        // Scramble the inputs after the accept cycle; they must be ignored.
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_mode  = ~m;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        e = sb.pop_front();
        chk({tag, " scan cycles"}, 64'(cnt), 64'(e.scans));
        chk_result(tag, e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk_result({tag, " hold"}, e);
        end
        // Offer a new input during the handshake; it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, " back to idle"}, 64'(in_ready), 64'd1);
        chk({tag, " valid dropped"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] r;
        logic        signed_build;
`ifdef NORMALIZER_SIGNED_EN
        signed_build = 1'b1;
`else
        signed_build = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset in_ready",  64'(in_ready),  64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data",  out_data,       64'd0);
        chk("reset out_param", 64'(out_param), 64'd0);
        chk("reset out_count", 64'(out_count), 64'd0);
        chk("reset out_zero",  64'(out_zero),  64'd0);
        rst_n = 1'b1;

        run_op("u one",     64'h0000_0000_0000_0001, 1'b0, 0);
        run_op("u msb",     64'h8000_0000_0000_0000, 1'b0, 0);
        run_op("u zero",    64'h0, 1'b0, 0);
        run_op("s zero",    64'h0, 1'b1, 0);
        run_op("s ones",    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        run_op("s pos",     64'h0008_0000_0000_0000, 1'b1, 0);
        run_op("u k12",     64'h0008_0000_0000_0000, 1'b0, 0);
        run_op("s neg",     64'hFFF0_0000_1234_0000, 1'b1, 0);
        run_op("u hold",    64'h0000_0000_0001_2345, 1'b0, 5);

        // Spot-check the model against known answers.
        if (!signed_build) chk("model s ones ignored", 64'(model(64'hFFFF_FFFF_FFFF_FFFF, 1'b1).k), 64'd0);
        chk("model u one k", 64'(model(64'h1, 1'b0).k), 64'd63);

        for (int i = 0; i < 8; i++) begin
            r = {$urandom, $urandom} >> $urandom_range(0, 63);
            run_op("rand", r, 1'($urandom_range(0, 1)), 0);
        end

        // Reset in the middle of a SCAN.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'h1;
        in_mode  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid-scan busy", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst in_ready",  64'(in_ready),  64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_count", 64'(out_count), 64'd0);
        chk("rst out_data",  out_data,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after rst", 64'h0000_0100_0000_0000, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/normalizer.md
NORMALIZER -- requirements
Module: normalizer

Interface
REQ-001 SHALL have parameter STEP, default 8, meaning the maximum left-shift bits per SCAN cycle; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the in_data/in_mode offer is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an input.
REQ-006 SHALL have port in_data, input, 64 bits: the mantissa to normalize.
REQ-007 SHALL have port in_mode, input, 1 bit: 0 = unsigned normalization, 1 = signed normalization.
REQ-008 SHALL have port out_valid, output, 1 bit: the result outputs are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_data, output, 64 bits: the normalized mantissa.
REQ-011 SHALL have port out_param, output, 7 bits: the shift parameter in barrel-shifter encoding.
REQ-012 SHALL have port out_count, output, 6 bits: the left-shift count k applied.
REQ-013 SHALL have port out_zero, output, 1 bit: the input was all zeros.

Function
REQ-014 SHALL implement states IDLE, SCAN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, on in_valid&in_ready the block SHALL latch in_data and in_mode, clear the count, and go to DONE if in_data==0 (out_zero=1, out_data=0, k=0), else go to SCAN.
REQ-016 Each SCAN cycle SHALL compute z = number of redundant leading bits in the top window, capped at STEP and at 63-k.
- Unsigned: redundant bits are leading zeros.
- Signed: redundant bits are leading bits equal to bit63, minus 1, over a STEP+1-bit window.
REQ-017 Each SCAN cycle SHALL shift the working register left logically by z, set k=k+z, and leave SCAN for DONE when z<STEP or k==63.
REQ-018 Normalized form SHALL be: bit63=1 (unsigned), or bit63!=bit62 (signed); otherwise k=63 when the cap is reached.
REQ-019 out_param SHALL equal {1'b0, (64-k) mod 64}, so feeding out_param to the team barrel shifter's left logical shift reproduces out_data; for example k=0 gives 7'h00 and k=12 gives 7'h34.
REQ-020 Latency SHALL be 1 accept cycle plus 1..ceil(63/STEP) SCAN cycles; out_valid SHALL rise the cycle after the last SCAN cycle.
REQ-021 In DONE, all outputs SHALL hold stable until out_ready=1; on out_ready the block SHALL return to IDLE, with no same-cycle acceptance of a new input.
REQ-022 in_data and in_mode changes SHALL be ignored outside the accept cycle.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE at any time, including mid-SCAN or in DONE, and SHALL discard any operation in flight.
REQ-024 Reset values SHALL be in_ready=1, out_valid=0, out_data=0, out_param=0, out_count=0 and out_zero=0.

Configuration
REQ-025 With NORMALIZER_SIGNED_EN defined, in_mode SHALL select the normalization mode per REQ-016.
REQ-026 Without NORMALIZER_SIGNED_EN, in_mode SHALL be ignored and the block SHALL always perform unsigned normalization; the port SHALL remain present.

Verification
REQ-027 Unsigned 64'h0000_0000_0000_0001, STEP=8 -> out_data=64'h8000_0000_0000_0000, out_count=63, out_param=7'h01, after 8 SCAN cycles.
REQ-028 Unsigned 64'h8000_0000_0000_0000 -> out_count=0, out_param=7'h00, out_data unchanged, after 1 SCAN cycle.
REQ-029 Signed 64'hFFFF_FFFF_FFFF_FFFF -> out_count=63, out_data=64'h8000_0000_0000_0000; signed 64'h0008_0000_0000_0000 -> out_count=11, out_data=64'h4000_0000_0000_0000.
REQ-030 Input 0 -> out_zero=1, out_data=0, out_param=0, out_valid asserted 1 cycle after accept.
REQ-031 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-032 Assert rst_n=0 during SCAN -> out_valid=0 and in_ready=1 immediately; a new input afterwards gives the correct result.
